// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port and one ALU, with a ready handshake and an illegal-op trap.
module ctrl_mc #(
  parameter bit BRANCH_EXT = 1'b1,
  parameter bit MEM_WAIT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       LtU,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] dbg_state
);

  // Memory handshake: a memory state completes in the cycle MemReady is high
  // (or immediately when memory is single-cycle). MemReq is the request "valid".
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t     state;
  state_t     decode_next;
  logic       ready;
  logic       alu_ok;
  logic       br_ok;
  logic       take;
  logic [2:0] alu_ctl;

  assign dbg_state = state;
  assign ready     = MemReady || (MEM_WAIT == 1'b0);

  always_comb begin
    alu_ok = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: alu_ok = 1'b1;
      default:                                alu_ok = 1'b0;
    endcase
  end

  assign br_ok = (funct3[2:1] == 2'b00) || (BRANCH_EXT && funct3[2]);

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = !Zero;
      3'b100:  take = Lt;
      3'b101:  take = !Lt;
      3'b110:  take = LtU;
      3'b111:  take = !LtU;
      default: take = 1'b0;
    endcase
  end

  // funct7 selects sub only for register-register ops; addi ignores it.
  always_comb begin
    alu_ctl = 3'b000;
    case (funct3)
      3'b000:  alu_ctl = (state == S_EXECR && funct7) ? 3'b001 : 3'b000;
      3'b100:  alu_ctl = 3'b100;
      3'b010:  alu_ctl = 3'b101;
      3'b110:  alu_ctl = 3'b011;
      3'b111:  alu_ctl = 3'b010;
      default: alu_ctl = 3'b000;
    endcase
  end

  always_comb begin
    decode_next = S_TRAP;
    case (op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_R:              decode_next = alu_ok ? S_EXECR : S_TRAP;
      OP_I:              decode_next = alu_ok ? S_EXECI : S_TRAP;
      OP_JAL:            decode_next = S_JAL;
      OP_BR:             decode_next = br_ok ? S_BRANCH : S_TRAP;
      default:           decode_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next;
        S_MEMADR:   state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_BRANCH:   state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs are gated by rst so an abandoned instruction never writes anything.
  always_comb begin
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    Illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = ready;
          PCWrite   = ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_JAL) ? 2'b11 : 2'b10;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_STORE) ? 2'b01 : 2'b00;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_ctl;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_ctl;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          PCWrite    = take;
        end
        S_TRAP:  Illegal = 1'b1;
        default: Illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Bench for ctrl_mc: an instruction-level planner pushes the expected output vector of
// every cycle; one negedge process compares the active DUT against it.
module tb_ctrl_mc;

  localparam int W = 18;

  logic clk;
  logic rst0, rst1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7, zero, lt, ltu, mem_ready;
  wire [W-1:0] o0, o1;
  wire [3:0] dbg0, dbg1;

  int sel;
  bit ext, mw;
  int n_checks, n_pass;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        tag_q[$];
  logic [W-1:0] act_hist[$];

  ctrl_mc #(.BRANCH_EXT(1'b1), .MEM_WAIT(1'b1)) dut0 (
    .clk(clk), .rst(rst0), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(zero), .Lt(lt), .LtU(ltu), .MemReady(mem_ready),
    .MemReq(o0[17]), .MemWrite(o0[16]), .PCWrite(o0[15]), .AdrSrc(o0[14]),
    .IRWrite(o0[13]), .RegWrite(o0[12]), .ImmSrc(o0[11:10]), .ALUSrcA(o0[9:8]),
    .ALUSrcB(o0[7:6]), .ResultSrc(o0[5:4]), .ALUControl(o0[3:1]), .Illegal(o0[0]),
    .dbg_state(dbg0)
  );

  ctrl_mc #(.BRANCH_EXT(1'b0), .MEM_WAIT(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(zero), .Lt(lt), .LtU(ltu), .MemReady(mem_ready),
    .MemReq(o1[17]), .MemWrite(o1[16]), .PCWrite(o1[15]), .AdrSrc(o1[14]),
    .IRWrite(o1[13]), .RegWrite(o1[12]), .ImmSrc(o1[11:10]), .ALUSrcA(o1[9:8]),
    .ALUSrcB(o1[7:6]), .ResultSrc(o1[5:4]), .ALUControl(o1[3:1]), .Illegal(o1[0]),
    .dbg_state(dbg1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [W-1:0] ov(input logic mreq, input logic mwr, input logic pcw,
                                      input logic adr, input logic irw, input logic rgw,
                                      input logic [1:0] imm, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic [2:0] alu, input logic ill);
    return {mreq, mwr, pcw, adr, irw, rgw, imm, sa, sb, rs, alu, ill};
  endfunction

  localparam logic [W-1:0] ALL     = '1;
  localparam logic [W-1:0] EN_MASK = 18'b111011_00_00_00_00_000_0;

  function automatic bit alu_legal(input logic [2:0] f);
    return (f == 3'd0) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6) || (f == 3'd7);
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f, input logic f7, input bit r);
    case (f)
      3'd0:    return (r && f7) ? 3'b001 : 3'b000;
      3'd4:    return 3'b100;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit br_legal(input logic [2:0] f);
    return (f == 3'd0) || (f == 3'd1) || (ext && f >= 3'd4);
  endfunction

  function automatic logic take_of(input logic [2:0] f, input logic z, input logic l, input logic lu);
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      3'd6:    return lu;
      default: return !lu;
    endcase
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] a, e, m;
    string t;
    if (exp_q.size() > 0) begin
      a = (sel == 0) ? o0 : o1;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      act_hist.push_back(a);
      n_checks++;
      if ((a & m) === (e & m)) n_pass++;
      else $display("FAIL %s dut%0d got %h exp %h (mask %h) at %0t", t, sel, a & m, e & m, m, $time);
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [W-1:0] e, input logic [W-1:0] m, input string t);
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_flags();
    zero      = 1'($urandom_range(0, 1));
    lt        = 1'($urandom_range(0, 1));
    ltu       = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_rst(input logic v);
    if (sel == 0) begin rst0 = v; rst1 = 1'b1; end
    else begin rst1 = v; rst0 = 1'b1; end
  endtask

  task automatic ph_rst(input int k);
    set_rst(1'b1);
    for (int i = 0; i < k; i++) begin
      rnd_flags();
      step('0, EN_MASK, "reset");
    end
    set_rst(1'b0);
  endtask

  task automatic ph_fetch(input int waits);
    int w;
    w = mw ? waits : 0;
    for (int i = 0; i < w; i++) begin
      rnd_flags();
      mem_ready = 1'b0;
      step(ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 0), ALL, "fetch_wait");
    end
    rnd_flags();
    if (mw) mem_ready = 1'b1;
    step(ov(1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 0), ALL, "fetch");
  endtask

  task automatic ph_decode();
    rnd_flags();
    step(ov(0, 0, 0, 0, 0, 0, (op == 7'b1101111) ? 2'b11 : 2'b10, 2'b01, 2'b01, 2'b00, 3'b000, 0),
         ALL, "decode");
  endtask

  task automatic ph_trap(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_flags();
      step(ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), ALL, "trap");
    end
  endtask

  task automatic ph_memadr(input bit store);
    rnd_flags();
    step(ov(0, 0, 0, 0, 0, 0, store ? 2'b01 : 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), ALL, "memadr");
  endtask

  task automatic ph_mem(input bit wr, input int waits);
    int w;
    w = mw ? waits : 0;
    for (int i = 0; i < w; i++) begin
      rnd_flags();
      mem_ready = 1'b0;
      step(ov(1, wr, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), ALL, "mem_wait");
    end
    rnd_flags();
    if (mw) mem_ready = 1'b1;
    step(ov(1, wr, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), ALL, "mem_done");
  endtask

  task automatic ph_wb(input logic [1:0] rs);
    rnd_flags();
    step(ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, rs, 3'b000, 0), ALL, "writeback");
  endtask

  task automatic ph_exec(input bit r);
    rnd_flags();
    step(ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, r ? 2'b00 : 2'b01, 2'b00, alu_of(funct3, funct7, r), 0),
         ALL, r ? "execr" : "execi");
  endtask

  task automatic ph_jal();
    rnd_flags();
    step(ov(0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0), ALL, "jal");
  endtask

  task automatic ph_branch(input logic z, input logic l, input logic lu);
    rnd_flags();
    zero = z; lt = l; ltu = lu;
    step(ov(0, 0, take_of(funct3, z, l, lu), 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0),
         ALL, "branch");
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw, input int mwt);
    bit bad;
    op = o; funct3 = f3; funct7 = f7;
    ph_fetch(fw);
    ph_decode();
    bad = 1'b0;
    case (o)
      7'b0000011: begin ph_memadr(0); ph_mem(0, mwt); ph_wb(2'b01); end
      7'b0100011: begin ph_memadr(1); ph_mem(1, mwt); end
      7'b0110011: if (alu_legal(f3)) begin ph_exec(1); ph_wb(2'b00); end else bad = 1'b1;
      7'b0010011: if (alu_legal(f3)) begin ph_exec(0); ph_wb(2'b00); end else bad = 1'b1;
      7'b1101111: begin ph_jal(); ph_wb(2'b00); end
      7'b1100011: if (br_legal(f3))
                    ph_branch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                  else bad = 1'b1;
      default:    bad = 1'b1;
    endcase
    if (bad) begin
      ph_trap($urandom_range(1, 4));
      ph_rst($urandom_range(1, 2));
    end
  endtask

  task automatic run_random(input int n);
    logic [6:0] o;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       o = 7'b0000011;
        1:       o = 7'b0100011;
        2, 3:    o = 7'b0110011;
        4, 5:    o = 7'b0010011;
        6:       o = 7'b1101111;
        7, 8:    o = 7'b1100011;
        default: o = 7'($urandom_range(0, 127));
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, cnt;
    logic [W-1:0] v;
    n_checks = 0; n_pass = 0;
    sel = 0; ext = 1'b1; mw = 1'b1;
    rst0 = 1'b1; rst1 = 1'b1;
    op = '0; funct3 = '0; funct7 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // reset then lw with three memory wait cycles
    ph_rst(2);
    op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0;
    ph_fetch(0); ph_decode(); ph_memadr(0); ph_mem(0, 3); ph_wb(2'b01);
    v = act_hist[0];
    lit("rst_enables_zero", int'(v & EN_MASK), 0);
    v = act_hist[2];
    lit("rst_fetch_memreq", int'(v[17]), 1);
    lit("rst_fetch_irwrite", int'(v[13]), 1);
    lit("rst_fetch_pcwrite", int'(v[15]), 1);
    cnt = 0;
    for (int i = 5; i <= 7; i++) begin v = act_hist[i]; cnt += int'(v[14]); end
    lit("lw_wait_adrsrc", cnt, 3);
    v = act_hist[9];
    lit("lw_cyc8_regwrite", int'(v[12]), 1);
    lit("lw_cyc8_resultsrc", int'(v[5:4]), 1);

    // sw with one fetch wait and two memory waits
    b = act_hist.size();
    op = 7'b0100011; funct3 = 3'b010;
    ph_fetch(1); ph_decode(); ph_memadr(1); ph_mem(1, 2);
    cnt = 0;
    for (int i = 4; i <= 6; i++) begin v = act_hist[b + i]; cnt += int'(v[16]); end
    lit("sw_memwrite_cycles", cnt, 3);
    cnt = 0;
    for (int i = 0; i <= 6; i++) begin v = act_hist[b + i]; cnt += int'(v[12]); end
    lit("sw_no_regwrite", cnt, 0);

    // sub vs addi with funct7 set
    b = act_hist.size();
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0);
    v = act_hist[b + 2];
    lit("execr_sub", int'(v[3:1]), 1);
    b = act_hist.size();
    run_instr(7'b0010011, 3'b000, 1'b1, 0, 0);
    v = act_hist[b + 2];
    lit("execi_addi", int'(v[3:1]), 0);

    // branches
    b = act_hist.size();
    op = 7'b1100011; funct3 = 3'b000;
    ph_fetch(0); ph_decode(); ph_branch(1'b1, 1'b0, 1'b0);
    v = act_hist[b + 2];
    lit("beq_taken", int'(v[15]), 1);
    b = act_hist.size();
    funct3 = 3'b001;
    ph_fetch(0); ph_decode(); ph_branch(1'b1, 1'b0, 1'b0);
    v = act_hist[b + 2];
    lit("bne_not_taken", int'(v[15]), 0);
    b = act_hist.size();
    funct3 = 3'b100;
    ph_fetch(0); ph_decode(); ph_branch(1'b0, 1'b1, 1'b0);
    v = act_hist[b + 2];
    lit("blt_taken", int'(v[15]), 1);

    // jal
    b = act_hist.size();
    run_instr(7'b1101111, 3'b000, 1'b0, 0, 0);
    v = act_hist[b + 1];
    lit("jal_decode_immsrc", int'(v[11:10]), 3);
    v = act_hist[b + 3];
    lit("jal_wb_resultsrc", int'(v[5:4]), 0);

    // illegal opcode: trap held 10 cycles, then reset
    b = act_hist.size();
    op = 7'b1111111;
    ph_fetch(0); ph_decode(); ph_trap(10); ph_rst(1);
    cnt = 0;
    for (int i = 2; i < 12; i++) begin
      v = act_hist[b + i];
      if (v[0] == 1'b1 && (v & EN_MASK) == '0) cnt++;
    end
    lit("trap_held_10", cnt, 10);
    b = act_hist.size();
    run_instr(7'b0110011, 3'b110, 1'b0, 0, 0);
    v = act_hist[b];
    lit("trap_rst_fetch", int'(v[17]), 1);

    // reset while a store is waiting on memory
    b = act_hist.size();
    op = 7'b0100011;
    ph_fetch(0); ph_decode(); ph_memadr(1);
    set_rst(1'b1); rnd_flags(); mem_ready = 1'b1;
    step('0, EN_MASK, "sw_abort");
    set_rst(1'b0);
    v = act_hist[b + 3];
    lit("sw_abort_memwrite", int'(v[16]), 0);
    run_instr(7'b0010011, 3'b100, 1'b0, 0, 0);

    run_random(150);

    // second configuration: base branches only, single-cycle memory
    sel = 1; ext = 1'b0; mw = 1'b0;
    ph_rst(2);
    b = act_hist.size();
    op = 7'b1100011; funct3 = 3'b100;
    ph_fetch(0); ph_decode(); lt = 1'b1; ph_trap(3); ph_rst(1);
    v = act_hist[b + 2];
    lit("blt_noext_illegal", int'(v[0]), 1);
    b = act_hist.size();
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 3);
    lit("noext_lw_latency", act_hist.size() - b, 5);
    run_random(150);

    @(negedge clk); #1;
    lit("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
